// File: rtl/rggen_rtl_pkg.sv
// rggen_rtl_pkg: bus direction and response status types shared by rggen bus bridges.
package rggen_rtl_pkg;
  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;
endpackage

// File: rtl/rggen_bus_if.sv
// rggen_bus_if: register-block request/response bus between a master and a bus bridge.
interface rggen_bus_if
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32
);
  logic                       request;
  logic [ADDRESS_WIDTH-1:0]   address;
  rggen_direction             direction;
  logic [BUS_WIDTH-1:0]       write_data;
  logic [BUS_WIDTH/8-1:0]     write_strobe;
  logic                       done;
  logic [BUS_WIDTH-1:0]       read_data;
  rggen_status                status;

  modport master (
    output request, address, direction, write_data, write_strobe,
    input  done, read_data, status
  );

  modport slave (
    input  request, address, direction, write_data, write_strobe,
    output done, read_data, status
  );
endinterface

// File: rtl/rggen_bus_timeout_counter.sv
// rggen_bus_timeout_counter: counts stalled ACCESS cycles and flags the one that reaches CYCLES.
module rggen_bus_timeout_counter #(
  parameter int CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int CW = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);

  logic [CW-1:0] count_q, count_d;

  // Saturating so a stuck enable can never wrap back into a fresh budget
  always_comb begin
    count_d   = clear_i ? '0 : (enable_i && count_q != CW'(CYCLES)) ? count_q + 1'b1 : count_q;
    expired_o = enable_i && (count_q == CW'(CYCLES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end
endmodule

// File: rtl/rggen_apb_bridge.sv
// rggen_apb_bridge: converts one rggen bus request at a time into an APB4 transfer,
// with an optional ACCESS-phase timeout that completes the request as a slave error.
module rggen_apb_bridge
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  rggen_bus_if.slave                bus_if,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDRESS_WIDTH-1:0]  paddr,
  output logic [2:0]                pprot,
  output logic [DATA_WIDTH-1:0]     pwdata,
  output logic [DATA_WIDTH/8-1:0]   pstrb,
  input  logic                      pready,
  input  logic                      pslverr,
  input  logic [DATA_WIDTH-1:0]     prdata
);
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     write_q, write_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [SW-1:0]            strb_q, strb_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic                     err_q, err_d;
  logic                     start, complete, expired;

  assign start    = (state_q == IDLE) && bus_if.request;
  assign complete = (state_q == ACCESS) && (pready || expired);

  if (TIMEOUT_CYCLES > 0) begin : g_timeout
    rggen_bus_timeout_counter #(
      .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (start),
      .enable_i  ((state_q == ACCESS) && !pready),
      .expired_o (expired)
    );
  end else begin : g_no_timeout
    assign expired = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Timeout completion reports an error with no data; pready on that cycle wins
  always_comb begin
    state_d = (state_q == IDLE)   ? (bus_if.request ? SETUP : IDLE) :
              (state_q == SETUP)  ? ACCESS :
              (state_q == ACCESS) ? ((pready || expired) ? DONE : ACCESS) : IDLE;
    addr_d  = start ? bus_if.address : addr_q;
    write_d = start ? (bus_if.direction == RGGEN_WRITE) : write_q;
    wdata_d = start ? bus_if.write_data : wdata_q;
    strb_d  = start ? bus_if.write_strobe : strb_q;
    err_d   = complete ? (!pready || pslverr) : err_q;
    rdata_d = complete ? ((pready && !pslverr && !write_q) ? prdata : '0) : rdata_q;
  end

  always_comb begin
    psel             = (state_q == SETUP) || (state_q == ACCESS);
    penable          = (state_q == ACCESS);
    pwrite           = write_q;
    paddr            = addr_q;
    pprot            = 3'b000;
    pwdata           = write_q ? wdata_q : '0;
    pstrb            = write_q ? strb_q : '0;
    bus_if.done      = (state_q == DONE);
    bus_if.read_data = (state_q == DONE) ? rdata_q : '0;
    bus_if.status    = ((state_q == DONE) && err_q) ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;
  end
endmodule

// File: tb/tb_rggen_apb_bridge.sv
// tb_rggen_apb_bridge: randomized scoreboard bench for rggen_apb_bridge with an APB slave model.
module tb_rggen_apb_bridge;
  import rggen_rtl_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int T  = 4;

  typedef struct {
    logic [DW-1:0] rdata;
    rggen_status   status;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW)) bus_if ();

  logic          psel, penable, pwrite, pready, pslverr;
  logic [AW-1:0] paddr;
  logic [2:0]    pprot;
  logic [DW-1:0] pwdata, prdata;
  logic [SW-1:0] pstrb;

  rggen_apb_bridge #(
    .ADDRESS_WIDTH  (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus_if  (bus_if),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pprot   (pprot),
    .pwdata  (pwdata),
    .pstrb   (pstrb),
    .pready  (pready),
    .pslverr (pslverr),
    .prdata  (prdata)
  );

  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;
  exp_t q[$];
  exp_t e;

  logic [AW-1:0] t_addr;
  logic          t_write;
  logic [DW-1:0] t_wdata, t_rdata;
  logic [SW-1:0] t_strb;
  int            t_wait;
  logic          t_err;
  int            acc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a transfer whose slave stalls T or more cycles is cut off after T ACCESS cycles
  function automatic exp_t model(input logic w, input int wt, input logic er, input logic [DW-1:0] rd, input int t0);
    exp_t r;
    logic to;
    to       = (wt >= T);
    r.status = (to || er) ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;
    r.rdata  = (to || er || w) ? '0 : rd;
    r.cyc    = t0 + 3 + (to ? T - 1 : wt);
    return r;
  endfunction

  // APB slave: stalls t_wait ACCESS cycles, scrambles response fields while not ready
  always @(negedge clk) begin
    if (psel) begin
      check("apb_addr_dir", {paddr, pwrite, pprot}, {t_addr, t_write, 3'b000});
      check("apb_wdata_strb", {pwdata, pstrb}, {(t_write ? t_wdata : {DW{1'b0}}), (t_write ? t_strb : {SW{1'b0}})});
    end
    if (psel && penable) begin
      pready  = (acc == t_wait);
      prdata  = pready ? t_rdata : $urandom;
      pslverr = pready ? t_err : 1'($urandom_range(1));
      acc++;
    end else begin
      pready  = 1'b0;
      prdata  = $urandom;
      pslverr = 1'($urandom_range(1));
      acc     = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_if.done) begin
        if (q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending transfer (t=%0t)", $time);
        end else begin
          e = q.pop_front();
          check("read_data", bus_if.read_data, e.rdata);
          check("status", bus_if.status, e.status);
          check("done_cycle", cyc, e.cyc);
        end
      end else begin
        check("idle_read_data", bus_if.read_data, 0);
      end
    end
  end

  task automatic issue(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd, input logic [SW-1:0] s,
                       input int wt, input logic er, input logic [DW-1:0] rd, input logic push);
    t_addr = a; t_write = w; t_wdata = wd; t_strb = s; t_wait = wt; t_err = er; t_rdata = rd;
    bus_if.address      = a;
    bus_if.direction    = w ? RGGEN_WRITE : RGGEN_READ;
    bus_if.write_data   = wd;
    bus_if.write_strobe = s;
    bus_if.request      = 1'b1;
    if (push) q.push_back(model(w, wt, er, rd, cyc));
    @(negedge clk);
    if ($urandom_range(1) == 1) @(negedge clk);
    bus_if.request = 1'b0;
  endtask

  task automatic run_tx(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd, input logic [SW-1:0] s,
                        input int wt, input logic er, input logic [DW-1:0] rd, input logic req_in_done);
    int n;
    issue(a, w, wd, s, wt, er, rd, 1'b1);
    n = 0;
    while (!bus_if.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus_if.done) begin
      vectors++;
      errors++;
      $display("FAIL done_wait: got no done after %0d cycles expected done (t=%0t)", n, $time);
    end
    if (req_in_done) begin
      bus_if.request = 1'b1;
      @(negedge clk);
      bus_if.request = 1'b0;
      repeat (3) begin
        @(negedge clk);
        check("no_restart_from_done", psel, 0);
      end
    end else begin
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.request      = 1'b0;
    bus_if.address      = '0;
    bus_if.direction    = RGGEN_READ;
    bus_if.write_data   = '0;
    bus_if.write_strobe = '0;
    t_addr = '0; t_write = 1'b0; t_wdata = '0; t_strb = '0; t_wait = 0; t_err = 1'b0; t_rdata = '0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_apb", {psel, penable, pwrite, paddr, pstrb}, 0);
    check("reset_bus", {pwdata, bus_if.done, bus_if.read_data[15:0], bus_if.status}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_tx(16'h0010, 1'b1, 32'hA5A5_0001, 4'b0011, 0, 1'b0, 32'h1234_5678, 1'b0);
    run_tx(16'h0024, 1'b0, 32'h0, 4'b1111, 3, 1'b0, 32'hDEAD_BEEF, 1'b0);
    run_tx(16'h0028, 1'b0, 32'h0, 4'b0000, 1, 1'b1, 32'hCAFE_F00D, 1'b0);
    run_tx(16'h0030, 1'b0, 32'h0, 4'b0000, 10, 1'b0, 32'h0BAD_0BAD, 1'b0);
    run_tx(16'h0034, 1'b0, 32'h0, 4'b0000, T - 1, 1'b0, 32'h7777_1111, 1'b0);
    run_tx(16'h0038, 1'b1, 32'h5555_AAAA, 4'b1000, 0, 1'b0, 32'h0, 1'b1);

    issue(16'h0040, 1'b1, 32'h1111_2222, 4'b0101, 6, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 10 && !penable; i++) @(negedge clk);
    check("reached_access", penable, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_apb", {psel, penable, pwrite, paddr, pstrb}, 0);
    check("abort_bus", {pwdata, bus_if.done, bus_if.read_data[15:0], bus_if.status}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no_done_after_abort", {psel, bus_if.done}, 0);
    end
    run_tx(16'h0044, 1'b0, 32'h0, 4'b0000, 0, 1'b0, 32'h600D_600D, 1'b0);

    for (int i = 0; i < 40; i++)
      run_tx(AW'($urandom), 1'($urandom_range(1)), $urandom, SW'($urandom), int'($urandom_range(6)),
             1'($urandom_range(3) == 0), $urandom, 1'(i % 7 == 3));

    repeat (3) @(negedge clk);
    check("scoreboard_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/rggen_apb_bridge.md
RGGEN_APB_BRIDGE -- requirements
Module: rggen_apb_bridge

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 16, byte address width of bus_if and paddr.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width (multiple of 8).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 0, max ACCESS-phase wait cycles; 0 disables timeout.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-006 SHALL have port bus_if  rggen_bus_if.slave  -  request/address/direction/write_data/write_strobe in; done/read_data/status out.
REQ-007 SHALL have port psel, penable, pwrite  output  1 each  APB4 control.
REQ-008 SHALL have port paddr  output  ADDRESS_WIDTH  APB4 address.
REQ-009 SHALL have port pprot  output  3  APB4 protection, constant 3'b000.
REQ-010 SHALL have port pwdata  output  DATA_WIDTH;  pstrb  output  DATA_WIDTH/8.
REQ-011 SHALL have port pready, pslverr  input  1 each;  prdata  input  DATA_WIDTH.

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, ACCESS, DONE.
REQ-013 IDLE: bus_if.request=1 SHALL capture address, direction, write_data, write_strobe into holding registers and go to SETUP next edge.
REQ-014 SETUP: psel=1, penable=0, captured fields on APB; unconditional move to ACCESS next edge.
REQ-015 ACCESS: psel=1, penable=1; paddr/pwrite/pwdata/pstrb held stable from SETUP.
REQ-016 ACCESS with pready=1 SHALL capture prdata (read only, else 0) and pslverr, go to DONE.
REQ-017 DONE: bus_if.done=1 for exactly one cycle, psel=penable=0; return to IDLE next edge.
REQ-018 bus_if.status SHALL be RGGEN_OKAY, or RGGEN_SLAVE_ERROR if captured pslverr=1 or timeout; valid only while done=1.
REQ-019 bus_if.read_data SHALL equal captured data while done=1, else 0.
REQ-020 pwrite = (direction==RGGEN_WRITE); pstrb = write_strobe on writes, all-zero on reads; pwdata = 0 on reads.
REQ-021 Timeout: counter clears on SETUP entry, increments each ACCESS cycle with pready=0; at TIMEOUT_CYCLES goes to DONE with SLAVE_ERROR, read_data 0.
REQ-022 pready=1 on the timeout cycle SHALL win (normal completion).
REQ-023 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1), min 1; saturates, never wraps.
REQ-024 bus_if.request deasserted mid-transaction SHALL be ignored; the APB transfer completes and done still pulses.
REQ-025 DONE-to-IDLE SHALL not restart on the DONE cycle's request; next transfer needs request=1 in IDLE.
REQ-026 Request-to-done latency SHALL be 3 + N cycles, N = ACCESS wait cycles (N=0 pready immediate).

Reset
REQ-027 rst_n=0 SHALL force IDLE; psel, penable, pwrite, paddr, pwdata, pstrb, done, read_data, counter to 0; status RGGEN_OKAY.
REQ-028 Reset mid-transfer SHALL abort it immediately with no done pulse; operation resumes first edge after release.

Structure
REQ-029 rggen_direction and rggen_status SHALL come from rggen_rtl_pkg; FSM state enum stays local.
REQ-030 Timeout counter SHALL be sub-module rggen_bus_timeout_counter (clear, enable, expired), tied off when TIMEOUT_CYCLES=0.

Verification
REQ-031 Write 0x0010, data 0xA5A5_0001, strobe 4'b0011, pready on first ACCESS -> SETUP/ACCESS one cycle each, pstrb=0011, done on 4th cycle, status OKAY.
REQ-032 Read 0x0024, pready after 3 wait cycles, prdata 0xDEAD_BEEF -> read_data 0xDEAD_BEEF at done, latency 6, pstrb=0.
REQ-033 Read with pslverr=1 at completion -> status SLAVE_ERROR, read_data 0.
REQ-034 TIMEOUT_CYCLES=4, pready held 0 -> DONE after 4 ACCESS cycles, status SLAVE_ERROR; repeat with pready rising on 4th cycle -> OKAY.
REQ-035 rst_n pulsed low during ACCESS -> all outputs 0 at once, no done; next request after release completes normally.
REQ-036 Back-to-back: request reasserted cycle after done -> second SETUP starts next cycle, no lost or duplicated transfer.
